// File: rtl/serial_pattern_tx.sv
//------------------------------------------------------------------------------
// Module   : serial_pattern_tx
// Purpose  : Parallel-to-serial MSB-first pattern transmitter with load/ready
//            handshake, per-bit valid, last-bit flag and programmable idle gap.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module serial_pattern_tx #(
  parameter int WIDTH      = 18,
  parameter int GAP        = 2,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load,
  output logic             ready,
  output logic             X,
  output logic             x_valid,
  output logic             done,
  output logic             busy
);

  localparam int                c_CW       = $clog2(WIDTH);
  localparam logic [c_CW-1:0]   c_BIT_LAST = c_CW'(WIDTH - 1);
  localparam logic [3:0]        c_GAP_LAST = 4'((GAP > 0) ? (GAP - 1) : 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t           r_state,  w_state_nxt;
  logic [WIDTH-1:0] r_shift,  w_shift_nxt;
  logic [c_CW-1:0]  r_bitcnt, w_bitcnt_nxt;
  logic [3:0]       r_gapcnt, w_gapcnt_nxt;

  logic w_in_shift;
  logic w_done;
  logic w_ready;

  // Every output is a decode of registered state; load/data_in never reach them.
  assign w_in_shift = (r_state == S_SHIFT);
  assign w_done     = w_in_shift && (r_bitcnt == '0);
  assign w_ready    = (r_state == S_IDLE) || ((GAP == 0) && w_done);

  assign X       = w_in_shift ? r_shift[WIDTH-1] : IDLE_LEVEL;
  assign x_valid = w_in_shift;
  assign done    = w_done;
  assign busy    = (r_state != S_IDLE);
  assign ready   = w_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_shift  <= '0;
      r_bitcnt <= '0;
      r_gapcnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_shift  <= w_shift_nxt;
      r_bitcnt <= w_bitcnt_nxt;
      r_gapcnt <= w_gapcnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_shift_nxt  = r_shift;
    w_bitcnt_nxt = r_bitcnt;
    w_gapcnt_nxt = r_gapcnt;
    case (r_state)
      S_IDLE: begin
        if (load) begin
          w_shift_nxt  = data_in;
          w_bitcnt_nxt = c_BIT_LAST;
          w_state_nxt  = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (r_bitcnt == '0) begin
          if (GAP > 0) begin
            w_gapcnt_nxt = c_GAP_LAST;
            w_state_nxt  = S_GAP;
          end else if (load) begin
            // Back-to-back: next word's first bit follows the last bit directly.
            w_shift_nxt  = data_in;
            w_bitcnt_nxt = c_BIT_LAST;
            w_state_nxt  = S_SHIFT;
          end else begin
            w_state_nxt  = S_IDLE;
          end
        end else begin
          w_shift_nxt  = {r_shift[WIDTH-2:0], 1'b0};
          w_bitcnt_nxt = r_bitcnt - 1'b1;
        end
      end
      S_GAP: begin
        if (r_gapcnt == '0) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_gapcnt_nxt = r_gapcnt - 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_serial_pattern_tx.sv
//------------------------------------------------------------------------------
// Module   : tb_serial_pattern_tx
// Purpose  : Directed self-checking bench for serial_pattern_tx in three
//            parameterisations (default, back-to-back, idle-high with gap 3).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_serial_pattern_tx;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // DUT0: WIDTH=18, GAP=2, IDLE_LEVEL=0
  logic [17:0] d0_data = '0;
  logic        d0_load = 1'b0;
  logic        d0_ready, d0_x, d0_xv, d0_done, d0_busy;
  // DUT1: WIDTH=4, GAP=0
  logic [3:0]  d1_data = '0;
  logic        d1_load = 1'b0;
  logic        d1_ready, d1_x, d1_xv, d1_done, d1_busy;
  // DUT2: WIDTH=18, GAP=3, IDLE_LEVEL=1
  logic [17:0] d2_data = '0;
  logic        d2_load = 1'b0;
  logic        d2_ready, d2_x, d2_xv, d2_done, d2_busy;

  serial_pattern_tx #(.WIDTH(18), .GAP(2), .IDLE_LEVEL(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .data_in(d0_data), .load(d0_load),
    .ready(d0_ready), .X(d0_x), .x_valid(d0_xv), .done(d0_done), .busy(d0_busy));

  serial_pattern_tx #(.WIDTH(4), .GAP(0), .IDLE_LEVEL(1'b0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .data_in(d1_data), .load(d1_load),
    .ready(d1_ready), .X(d1_x), .x_valid(d1_xv), .done(d1_done), .busy(d1_busy));

  serial_pattern_tx #(.WIDTH(18), .GAP(3), .IDLE_LEVEL(1'b1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .data_in(d2_data), .load(d2_load),
    .ready(d2_ready), .X(d2_x), .x_valid(d2_xv), .done(d2_done), .busy(d2_busy));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Hand-derived bit sequence for 18'h31D3C, first transmitted bit at index 17.
  logic [17:0] exp_bits = 18'b110001110100111100;
  logic [3:0]  exp_b2b  = 4'b1010;
  logic [3:0]  exp_b2b2 = 4'b0101;

  initial begin
    // ---------------- asynchronous reset, before any clock edge ----------------
    #2 rst_n = 1'b0;
    #1;
    check("rst_ready",  {31'd0, d0_ready}, 32'd1);
    check("rst_xvalid", {31'd0, d0_xv},    32'd0);
    check("rst_x",      {31'd0, d0_x},     32'd0);
    check("rst_busy",   {31'd0, d0_busy},  32'd0);
    check("rst_done",   {31'd0, d0_done},  32'd0);
    check("rst_x_il1",  {31'd0, d2_x},     32'd1);
    check("rst_ready1", {31'd0, d1_ready}, 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // ---------------- basic word on DUT0 ----------------
    d0_data = 18'h31D3C;
    d0_load = 1'b1;
    @(posedge clk);
    #1 d0_load = 1'b0;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      check("basic_x",     {31'd0, d0_x},     {31'd0, exp_bits[17-i]});
      check("basic_xv",    {31'd0, d0_xv},    32'd1);
      check("basic_done",  {31'd0, d0_done},  (i == 17) ? 32'd1 : 32'd0);
      check("basic_ready", {31'd0, d0_ready}, 32'd0);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("gap_x",     {31'd0, d0_x},     32'd0);
      check("gap_xv",    {31'd0, d0_xv},    32'd0);
      check("gap_busy",  {31'd0, d0_busy},  32'd1);
      check("gap_ready", {31'd0, d0_ready}, 32'd0);
    end
    @(negedge clk);
    check("post_ready", {31'd0, d0_ready}, 32'd1);
    check("post_busy",  {31'd0, d0_busy},  32'd0);

    // ---------------- back-to-back on DUT1 ----------------
    d1_data = 4'hA;
    d1_load = 1'b1;
    @(posedge clk);
    #1 d1_data = 4'h5;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("b2b_x",     {31'd0, d1_x},
            {31'd0, (i < 4) ? exp_b2b[3-i] : exp_b2b2[7-i]});
      check("b2b_xv",    {31'd0, d1_xv},    32'd1);
      check("b2b_done",  {31'd0, d1_done},  (i == 3 || i == 7) ? 32'd1 : 32'd0);
      check("b2b_ready", {31'd0, d1_ready}, (i == 3 || i == 7) ? 32'd1 : 32'd0);
      check("b2b_busy",  {31'd0, d1_busy},  32'd1);
      if (i == 7) d1_load = 1'b0;
    end
    @(negedge clk);
    check("b2b_end_xv",    {31'd0, d1_xv},    32'd0);
    check("b2b_end_ready", {31'd0, d1_ready}, 32'd1);

    // ---------------- ignored load during SHIFT on DUT0 ----------------
    d0_data = 18'h3FFFF;
    d0_load = 1'b1;
    @(posedge clk);
    #1 d0_data = 18'h00000;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      check("ign_x",     {31'd0, d0_x},     32'd1);
      check("ign_xv",    {31'd0, d0_xv},    32'd1);
      check("ign_ready", {31'd0, d0_ready}, 32'd0);
      if (i == 17) d0_load = 1'b0;
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("ign_noextra_xv", {31'd0, d0_xv}, 32'd0);
    end

    // ---------------- reset mid-word on DUT0 ----------------
    d0_data = 18'h31D3C;
    d0_load = 1'b1;
    @(posedge clk);
    #1 d0_load = 1'b0;
    repeat (7) @(negedge clk);
    check("mid_pre_xv", {31'd0, d0_xv}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_x",     {31'd0, d0_x},     32'd0);
    check("mid_xv",    {31'd0, d0_xv},    32'd0);
    check("mid_busy",  {31'd0, d0_busy},  32'd0);
    check("mid_ready", {31'd0, d0_ready}, 32'd1);
    @(negedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("mid_after_xv",    {31'd0, d0_xv},    32'd0);
      check("mid_after_ready", {31'd0, d0_ready}, 32'd1);
    end

    // ---------------- IDLE_LEVEL=1, GAP=3 on DUT2 ----------------
    check("il1_pre_x",  {31'd0, d2_x},  32'd1);
    check("il1_pre_xv", {31'd0, d2_xv}, 32'd0);
    d2_data = 18'h00000;
    d2_load = 1'b1;
    @(posedge clk);
    #1 d2_load = 1'b0;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      check("il1_x",    {31'd0, d2_x},    32'd0);
      check("il1_xv",   {31'd0, d2_xv},   32'd1);
      check("il1_done", {31'd0, d2_done}, (i == 17) ? 32'd1 : 32'd0);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("il1_gap_x",    {31'd0, d2_x},    32'd1);
      check("il1_gap_xv",   {31'd0, d2_xv},   32'd0);
      check("il1_gap_busy", {31'd0, d2_busy}, 32'd1);
    end
    @(negedge clk);
    check("il1_idle_busy",  {31'd0, d2_busy},  32'd0);
    check("il1_idle_ready", {31'd0, d2_ready}, 32'd1);
    check("il1_idle_x",     {31'd0, d2_x},     32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/serial_pattern_tx.md
Name: serial_pattern_tx

Overview:
- Parallel-to-serial pattern transmitter that produces the single-bit X stream consumed by the sequence-detector blocks.
- Accepts a WIDTH-bit word through a load/ready handshake and shifts it out MSB-first on X, one bit per clk rising edge.
- Qualifies each bit with x_valid and flags the last bit of each word with done.
- Inserts a programmable idle gap between words, so detector benches and on-board demos can be driven from stored patterns instead of hand-written stimulus.

Parameters:
- WIDTH, 18, number of bits per word (valid range 2..32).
- GAP, 2, idle cycles between consecutive words (0..15). 0 allows back-to-back words.
- IDLE_LEVEL, 0, value driven on X whenever x_valid=0.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- data_in  input  WIDTH  word to transmit, sampled on an accepted load.
- load  input  1  request to transmit data_in.
- ready  output  1  block can accept a load this cycle.
- X  output  1  serial data, MSB first.
- x_valid  output  1  X carries a data bit this cycle.
- done  output  1  high during the cycle the last bit (bit 0) is on X.
- busy  output  1  high in SHIFT or GAP.

Behaviour:
- Interface is fixed: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset state, asserted immediately on rst_n=0 regardless of clk:
  - state=IDLE, shift register=0, bit counter=0, gap counter=0.
  - X=IDLE_LEVEL, x_valid=0, done=0, busy=0, ready=1.
- All outputs are registered or decoded from registered state only. No combinational path from load or data_in to any output.
- FSM states: IDLE, SHIFT, GAP.
- IDLE:
  - ready=1.
  - load=1 at a rising edge: capture data_in into the shift register, set bit counter to WIDTH-1, go to SHIFT.
  - load=0: stay in IDLE.
- SHIFT:
  - X = shift_reg[WIDTH-1], x_valid=1, busy=1.
  - Each edge: shift left by one (fill 0) and decrement the bit counter.
  - done=1 when bit counter==0 (last bit).
  - On the edge leaving the last bit:
    - GAP>0: load the gap counter with GAP-1 and go to GAP.
    - GAP==0: go to IDLE, or directly into a new SHIFT if a load is accepted that edge.
- GAP:
  - X=IDLE_LEVEL, x_valid=0, busy=1, ready=0.
  - Gap counter decrements each edge. At 0, go to IDLE.
- Latency:
  - First bit of a word appears on X exactly 1 cycle after the edge that accepts the load.
  - One word occupies WIDTH cycles of x_valid, then GAP idle cycles.
  - Word-to-word period: WIDTH+GAP+1 cycles (one IDLE cycle) when GAP>0; WIDTH when GAP==0 with load held.
- ready:
  - 1 in IDLE.
  - Also 1 during the done cycle when GAP==0, enabling a back-to-back load that edge.
  - 0 otherwise.
- load while ready=0 is ignored. No queueing, no error flag. data_in changes while busy have no effect.
- Reset mid-word aborts the word. After rst_n rises, the block is in IDLE with ready=1 and does not resume the aborted word.
- load asserted in the same cycle rst_n deasserts: not guaranteed accepted. Source must reassert load after seeing ready.
- Bit counter width: clog2(WIDTH). Counters never wrap: SHIFT exits at 0 and GAP exits at 0.

Test Plan:
- Reset then basic word:
  - Stimulus: defaults, release rst_n, pulse load one cycle with data_in=18'h31D3C.
  - Required: X = 1,1,0,0,0,1,1,1,0,1,0,0,1,1,1,1,0,0 on 18 consecutive cycles starting 1 cycle after the load edge.
  - Required: x_valid=1 for exactly those 18 cycles; done=1 only on the 18th; then 2 cycles X=0, x_valid=0, busy=1; then ready=1.
- Back-to-back:
  - Stimulus: GAP=0, WIDTH=4, load held high with data_in=4'hA then 4'h5.
  - Required: X = 1010 0101 with no x_valid gap; done high on cycles 4 and 8.
- Ignored load:
  - Stimulus: during SHIFT of 18'h3FFFF, assert load with data_in=0.
  - Required: the stream stays all-ones, no extra word, ready=0 throughout SHIFT.
- Reset mid-word:
  - Stimulus: assert rst_n=0 asynchronously (between edges) after bit 7.
  - Required: X=IDLE_LEVEL, x_valid=0, busy=0, ready=1 immediately. After release, no further bits until a new load.
- IDLE_LEVEL=1, GAP=3:
  - Stimulus: send 18'h00000.
  - Required: X=1 before the word, 18 cycles of 0 with x_valid=1, then 3 cycles of X=1 with x_valid=0.
- Loopback:
  - Stimulus: connect X to the sequence detector and send 18'h31D3C.
  - Required: detector Y matches the golden per-cycle trace for that pattern.
